// File: rtl/bm_job_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bm_job_arbiter                                             |
// | Description : Round-robin arbiter sharing one Berlekamp-Massey engine    |
// |               among NUM_CH syndrome producers. One job in flight; the    |
// |               engine's single-cycle result is held in a ready/valid      |
// |               result slot tagged with the producing channel.             |
// | Options     : BM_TIMEOUT_EN - enables a TIMEOUT_CYC watchdog on the      |
// |               engine; expiry returns C(x)=1 with res_err set.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bm_job_arbiter #(
   parameter int NUM_CH      = 4,
   parameter int CH_W        = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       req_valid,
   input  logic [NUM_CH*128-1:0]   req_data,
   output logic [NUM_CH-1:0]       req_ready,
   output logic [127:0]            bm_data_in,
   output logic                    bm_valid_in,
   input  logic [127:0]            bm_poly_out,
   input  logic                    bm_valid_out,
   input  logic                    bm_busy,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [127:0]            res_poly,
   output logic [CH_W-1:0]         res_ch,
   output logic                    res_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CH_W-1:0]   r_rr_ptr;
   logic [CH_W-1:0]   r_id;
   logic [127:0]      r_data;
   logic              r_res_valid;
   logic [127:0]      r_res_poly;
   logic [CH_W-1:0]   r_res_ch;

   logic              w_grant;
   logic              w_found;
   logic [CH_W-1:0]   w_winner;
   logic [CH_W-1:0]   w_cand;
   logic              w_capture;
   logic              w_timeout;

   // Elaboration-time sanity check of the parameter set
   if (CH_W != $clog2(NUM_CH) || NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYC < 2) begin : g_param_chk
      $error("bm_job_arbiter: inconsistent NUM_CH/CH_W/TIMEOUT_CYC");
   end

   // Channel index wrap modulo NUM_CH (NUM_CH need not be a power of two)
   function automatic logic [CH_W-1:0] f_wrap(input int v);
      return CH_W'(v % NUM_CH);
   endfunction

   // Round-robin search: first requesting channel at or after r_rr_ptr
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_cand   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_cand = f_wrap(int'(r_rr_ptr) + i);
         if (!w_found && req_valid[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   // A grant needs an idle engine (no stale done pulse) and a free or draining result slot
   assign w_grant   = (r_state == ST_IDLE) && !rst && w_found && !bm_busy && !bm_valid_out &&
                      (!r_res_valid || res_ready);
   assign req_ready = w_grant ? (NUM_CH'(1) << w_winner) : '0;
   assign w_capture = (r_state == ST_WAIT) && bm_valid_out;

   // Next-state logic; the engine's done pulse has priority over the watchdog
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_grant) w_state_nxt = ST_LAUNCH;
         ST_LAUNCH: w_state_nxt = ST_WAIT;
         ST_WAIT:   if (bm_valid_out || w_timeout) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // State register, round-robin pointer and the job latched on grant
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_rr_ptr <= '0;
         r_id     <= '0;
         r_data   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_data   <= req_data[int'(w_winner)*128 +: 128];
            r_id     <= w_winner;
            r_rr_ptr <= f_wrap(int'(w_winner) + 1);
         end
      end
   end

   assign bm_data_in  = r_data;
   assign bm_valid_in = (r_state == ST_LAUNCH);

   // Result slot: filled from the engine (or watchdog), drained by res_ready
   always_ff @(posedge clk) begin
      if (rst) begin
         r_res_valid <= 1'b0;
         r_res_poly  <= '0;
         r_res_ch    <= '0;
      end else begin
         if (r_res_valid && res_ready) r_res_valid <= 1'b0;
         if (w_capture) begin
            r_res_valid <= 1'b1;
            r_res_poly  <= bm_poly_out;
            r_res_ch    <= r_id;
         end else if (w_timeout) begin
            r_res_valid <= 1'b1;
            r_res_poly  <= 128'h1;
            r_res_ch    <= r_id;
         end
      end
   end

   assign res_valid = r_res_valid;
   assign res_poly  = r_res_poly;
   assign res_ch    = r_res_ch;

`ifdef BM_TIMEOUT_EN
   localparam int c_TMO_W = $clog2(TIMEOUT_CYC);

   logic [c_TMO_W-1:0] r_tmo_cnt;
   logic               r_res_err;

   // Cycles since launch: 0 in the LAUNCH cycle, k in the k-th cycle after it
   always_ff @(posedge clk) begin
      if (rst)                    r_tmo_cnt <= '0;
      else if (w_grant)           r_tmo_cnt <= '0;
      else if (r_state != ST_IDLE) r_tmo_cnt <= r_tmo_cnt + 1'b1;
   end

   // Expiry makes res_valid rise exactly TIMEOUT_CYC cycles after the launch cycle
   assign w_timeout = (r_state == ST_WAIT) && !bm_valid_out &&
                      (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYC - 1));

   // Error flag travels with the captured result
   always_ff @(posedge clk) begin
      if (rst)            r_res_err <= 1'b0;
      else if (w_capture) r_res_err <= 1'b0;
      else if (w_timeout) r_res_err <= 1'b1;
   end

   assign res_err = r_res_err;
`else
   assign w_timeout = 1'b0;
   assign res_err   = 1'b0;
`endif

endmodule
`default_nettype wire
